// File: rtl/parity_pkg.sv
// Encoding shared by the serializer and the downstream parity checker so both
// stages agree on the state values and the parity-mode polarity.
package parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_PAR  = 2'b10
  } state_t;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_serializer.sv
// Parallel-to-serial framer: shifts a WIDTH-bit word out LSB-first, then appends
// a parity bit so every WIDTH+1 bit frame has even (ODD=0) or odd (ODD=1) parity.
module parity_serializer
  import parity_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit ODD   = PAR_EVEN
) (
  input  logic             c,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             so,
  output logic             sv,
  output logic             last
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             p, p_n;
  logic             so_n, sv_n, last_n;
  logic             accept;

  // Ready in the parity cycle is what makes back-to-back frames gapless.
  assign ready  = !r && (state == S_IDLE || state == S_PAR);
  assign accept = load && ready;

  always_comb begin
    state_n = S_IDLE;
    sh_n    = sh;
    cnt_n   = cnt;
    p_n     = p;
    so_n    = 1'b0;
    sv_n    = 1'b0;
    last_n  = 1'b0;
    case (state)
      S_IDLE, S_PAR: begin
        if (accept) begin
          state_n = S_DATA;
          sh_n    = din >> 1;
          cnt_n   = '0;
          p_n     = (^din) ^ ODD;
          so_n    = din[0];
          sv_n    = 1'b1;
        end
      end
      S_DATA: begin
        sv_n = 1'b1;
        // cnt counts bits already driven; bit 0 went out on the accept edge
        if (cnt == CNT_LAST) begin
          state_n = S_PAR;
          so_n    = p;
          last_n  = 1'b1;
        end else begin
          state_n = S_DATA;
          so_n    = sh[0];
          sh_n    = sh >> 1;
          cnt_n   = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge c) begin
    if (r) begin
      state <= S_IDLE;
      sh    <= '0;
      cnt   <= '0;
      p     <= 1'b0;
      so    <= 1'b0;
      sv    <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      p     <= p_n;
      so    <= so_n;
      sv    <= sv_n;
      last  <= last_n;
    end
  end

endmodule
